// File: rtl/adder_pipe.sv
// adder_pipe: chunked carry-pipelined adder/subtractor.
// One CHUNK-bit slice per stage; latency STAGES, throughput one op per cycle.
module adder_pipe #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SAFE_CHUNK = (CHUNK > 0) ? CHUNK : 1;
   localparam int STAGES     = WIDTH / SAFE_CHUNK;
   localparam int L          = (STAGES > 0) ? STAGES - 1 : 0;
   localparam int NST        = (STAGES > 0) ? STAGES : 1;
   localparam bit BAD        = (CHUNK < 1) || (WIDTH < 1) ||
                               (WIDTH % SAFE_CHUNK != 0);

   generate
      if (BAD) begin : g_bad
         $error("adder_pipe: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   // stage k inputs: operands, partial sum so far, carry and valid token
   logic [WIDTH-1:0] ia [NST];
   logic [WIDTH-1:0] ib [NST];
   logic [WIDTH-1:0] ps [NST];
   logic [NST-1:0]   ic;
   logic [NST-1:0]   iv;

   logic [WIDTH-1:0] ns [NST];
   logic [NST-1:0]   nc;
   logic             nov;

   logic [WIDTH-1:0] aq [NST];
   logic [WIDTH-1:0] bq [NST];
   logic [WIDTH-1:0] sq [NST];
   logic [NST-1:0]   cq;
   logic [NST-1:0]   vq;
   logic             oq;

   // subtract folds into the add as a + ~b + 1, so sub need not travel
   always_comb begin
      ia[0] = a;
      ib[0] = b ^ {WIDTH{sub}};
      ps[0] = '0;
      ic[0] = sub | cin;
      iv[0] = in_valid;
      for (int k = 1; k < NST; k++) begin
         ia[k] = aq[k-1];
         ib[k] = bq[k-1];
         ps[k] = sq[k-1];
         ic[k] = cq[k-1];
         iv[k] = vq[k-1];
      end
   end

   always_comb begin
      logic [SAFE_CHUNK:0] t;
      t = '0;
      for (int k = 0; k < NST; k++) begin
         t = {1'b0, ia[k][k*SAFE_CHUNK +: SAFE_CHUNK]}
           + {1'b0, ib[k][k*SAFE_CHUNK +: SAFE_CHUNK]}
           + {{SAFE_CHUNK{1'b0}}, ic[k]};
         ns[k] = ps[k];
         ns[k][k*SAFE_CHUNK +: SAFE_CHUNK] = t[SAFE_CHUNK-1:0];
         nc[k] = t[SAFE_CHUNK];
      end
   end

   // carry into the MSB is recovered from the MSB sum bit
   assign nov = ia[L][WIDTH-1] ^ ib[L][WIDTH-1]
              ^ ns[L][WIDTH-1] ^ nc[L];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vq <= '0;
         cq <= '0;
         oq <= 1'b0;
         for (int k = 0; k < NST; k++) begin
            sq[k] <= '0;
         end
      end else begin
         vq <= iv;
         for (int k = 0; k < NST; k++) begin
            if (iv[k]) begin
               sq[k] <= ns[k];
               cq[k] <= nc[k];
            end
         end
         if (iv[L]) begin
            oq <= nov;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NST; k++) begin
         if (iv[k]) begin
            aq[k] <= ia[k];
            bq[k] <= ib[k];
         end
      end
   end

   assign out_valid = vq[L];
   assign sum       = sq[L];
   assign cout      = cq[L];
   assign ovf       = oq;

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed and random checks of adder_pipe at
// CHUNK = 8, 32 and 1 (latencies 4, 1 and 32) driven in parallel.
module tb_adder_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a, b;
   logic        cin, sub;
   logic [2:0]  ov, co, of;
   logic [31:0] sm [3];

   int n_cmp = 0;
   int n_err = 0;
   int lat [3];

   always #5 clk = ~clk;

   adder_pipe #(.WIDTH(32), .CHUNK(8)) u_c8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov[0]), .sum(sm[0]), .cout(co[0]), .ovf(of[0])
   );

   adder_pipe #(.WIDTH(32), .CHUNK(32)) u_c32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov[1]), .sum(sm[1]), .cout(co[1]), .ovf(of[1])
   );

   adder_pipe #(.WIDTH(32), .CHUNK(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov[2]), .sum(sm[2]), .cout(co[2]), .ovf(of[2])
   );

   // reference: {cout, ovf, sum}
   function automatic logic [33:0] model(
      input logic [31:0] x, input logic [31:0] y,
      input logic ci, input logic s);
      logic [31:0] ey;
      logic [32:0] r;
      logic        v;
      ey = s ? ~y : y;
      r  = {1'b0, x} + {1'b0, ey} + (s ? 33'd1 : {32'd0, ci});
      v  = (x[31] == ey[31]) && (r[31] != x[31]);
      return {r[32], v, r[31:0]};
   endfunction

   task automatic test_reset();
      logic [34:0] got;
      rst_n = 1'b0; in_valid = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         got = {ov[d], co[d], of[d], sm[d]};
         n_cmp++;
         if (got !== 35'd0) begin
            n_err++;
            $display("FAIL reset_state dut%0d: got %h want 0", d, got);
         end
      end
      rst_n = 1'b1; in_valid = 1'b1; a = 32'd3; b = 32'd4;
      for (int c = 1; c <= 33; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         for (int d = 0; d < 3; d++) begin
            got = {ov[d], co[d], of[d], sm[d]};
            if (c < lat[d]) begin
               n_cmp++;
               if (ov[d] !== 1'b0) begin
                  n_err++;
                  $display("FAIL first_op_early dut%0d c%0d: got %b want 0", d, c, ov[d]);
               end
            end else begin
               n_cmp++;
               if (got !== {c == lat[d], 2'b00, 32'd7}) begin
                  n_err++;
                  $display("FAIL first_op dut%0d c%0d: got %h want %h", d, c, got,
                           {c == lat[d], 2'b00, 32'd7});
               end
            end
         end
      end
   endtask

   task automatic test_ripple();
      logic [34:0] got;
      @(negedge clk);
      a = 32'hFFFF_FFFF; b = 32'd0; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         for (int d = 0; d < 3; d++) begin
            got = {ov[d], co[d], of[d], sm[d]};
            if (c < lat[d]) begin
               n_cmp++;
               if (ov[d] !== 1'b0) begin
                  n_err++;
                  $display("FAIL ripple_early dut%0d c%0d: got %b want 0", d, c, ov[d]);
               end
            end else begin
               n_cmp++;
               if (got !== {c == lat[d], 2'b10, 32'd0}) begin
                  n_err++;
                  $display("FAIL ripple dut%0d c%0d: got %h want %h", d, c, got,
                           {c == lat[d], 2'b10, 32'd0});
               end
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic [34:0] got;
      @(negedge clk);
      a = 32'h7FFF_FFFF; b = 32'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         for (int d = 0; d < 3; d++) begin
            got = {ov[d], co[d], of[d], sm[d]};
            if (c < lat[d]) begin
               n_cmp++;
               if (ov[d] !== 1'b0) begin
                  n_err++;
                  $display("FAIL ovf_early dut%0d c%0d: got %b want 0", d, c, ov[d]);
               end
            end else begin
               n_cmp++;
               if (got !== {c == lat[d], 2'b01, 32'h8000_0000}) begin
                  n_err++;
                  $display("FAIL ovf dut%0d c%0d: got %h want %h", d, c, got,
                           {c == lat[d], 2'b01, 32'h8000_0000});
               end
            end
         end
      end
   endtask

   task automatic test_sub();
      logic [34:0] got;
      @(negedge clk);
      a = 32'd5; b = 32'd7; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            got = {ov[d], co[d], of[d], sm[d]};
            if (c < lat[d]) begin
               n_cmp++;
               if (ov[d] !== 1'b0) begin
                  n_err++;
                  $display("FAIL sub_early dut%0d c%0d: got %b want 0", d, c, ov[d]);
               end
            end else if (c == lat[d]) begin
               n_cmp++;
               if (got !== {1'b1, 2'b00, 32'hFFFF_FFFE}) begin
                  n_err++;
                  $display("FAIL sub_5m7 dut%0d: got %h want %h", d, got,
                           {1'b1, 2'b00, 32'hFFFF_FFFE});
               end
            end else begin
               n_cmp++;
               if (got !== {c == lat[d] + 1, 2'b10, 32'd2}) begin
                  n_err++;
                  $display("FAIL sub_7m5 dut%0d c%0d: got %h want %h", d, c, got,
                           {c == lat[d] + 1, 2'b10, 32'd2});
               end
            end
         end
         if (c == 1) begin
            a = 32'd7; b = 32'd5; cin = 1'b0;
         end else begin
            in_valid = 1'b0; sub = 1'b0;
         end
      end
   endtask

   task automatic test_flush();
      logic [34:0] got;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 32'h100 + i; b = 32'h11; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         got = {ov[d], co[d], of[d], sm[d]};
         n_cmp++;
         if (got !== 35'd0) begin
            n_err++;
            $display("FAIL flush_zero dut%0d: got %h want 0", d, got);
         end
      end
      rst_n = 1'b1; a = 32'd10; b = 32'd20; in_valid = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         for (int d = 0; d < 3; d++) begin
            got = {ov[d], co[d], of[d], sm[d]};
            if (c < lat[d]) begin
               n_cmp++;
               if (got !== 35'd0) begin
                  n_err++;
                  $display("FAIL flush_discard dut%0d c%0d: got %h want 0", d, c, got);
               end
            end else begin
               n_cmp++;
               if (got !== {c == lat[d], 2'b00, 32'd30}) begin
                  n_err++;
                  $display("FAIL flush_new dut%0d c%0d: got %h want %h", d, c, got,
                           {c == lat[d], 2'b00, 32'd30});
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic        hv [512];
      logic [31:0] ha [512];
      logic [31:0] hb [512];
      logic        hc [512];
      logic        hs [512];
      logic [33:0] held [3];
      bit          seen [3];
      logic [33:0] exp;
      logic [34:0] got;
      int          issued;
      int          last;
      int          s;
      issued = 0;
      last = 0;
      for (int d = 0; d < 3; d++) begin
         seen[d] = 1'b0;
         held[d] = '0;
      end
      for (int t = 0; t < 512; t++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (t >= lat[d]) begin
               s = t - lat[d];
               got = {ov[d], co[d], of[d], sm[d]};
               if (hv[s]) begin
                  exp = model(ha[s], hb[s], hc[s], hs[s]);
                  n_cmp++;
                  if (got !== {1'b1, exp}) begin
                     n_err++;
                     $display("FAIL rand_op dut%0d t%0d: got %h want %h", d, t, got, {1'b1, exp});
                  end
                  held[d] = exp;
                  seen[d] = 1'b1;
               end else if (seen[d]) begin
                  n_cmp++;
                  if (got !== {1'b0, held[d]}) begin
                     n_err++;
                     $display("FAIL rand_hold dut%0d t%0d: got %h want %h", d, t, got, {1'b0, held[d]});
                  end
               end
            end
         end
         if (issued < 100 && $urandom_range(0, 3) != 0) begin
            hv[t] = 1'b1;
            issued++;
            last = t;
         end else begin
            hv[t] = 1'b0;
         end
         ha[t] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         hb[t] = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
         hc[t] = 1'($urandom_range(0, 1));
         hs[t] = 1'($urandom_range(0, 1));
         a = ha[t]; b = hb[t]; cin = hc[t]; sub = hs[t]; in_valid = hv[t];
         if (issued == 100 && t >= last + 33) break;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (issued != 100) begin
         n_err++;
         $display("FAIL rand_issue_budget: got %0d want 100", issued);
      end
   endtask

   initial begin
      lat[0] = 4;
      lat[1] = 1;
      lat[2] = 32;
      test_reset();
      test_ripple();
      test_overflow();
      test_sub();
      test_flush();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, bits added per pipeline stage.
REQ-003 The block SHALL derive STAGES = WIDTH/CHUNK, default 4, which is also the latency in cycles.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, operands present this cycle.
REQ-007 The block SHALL have port a, input, WIDTH, operand A.
REQ-008 The block SHALL have port b, input, WIDTH, operand B.
REQ-009 The block SHALL have port cin, input, 1, carry-in, used in add mode only.
REQ-010 The block SHALL have port sub, input, 1, 0 = add, 1 = subtract (a - b).
REQ-011 The block SHALL have port out_valid, output, 1, result present this cycle.
REQ-012 The block SHALL have port sum, output, WIDTH, result.
REQ-013 The block SHALL have port cout, output, 1, carry-out of the MSB.
REQ-014 The block SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-015 The block SHALL fail elaboration if WIDTH % CHUNK != 0, CHUNK < 1 or WIDTH < 1.
REQ-016 The block SHALL compute {cout,sum} = a + b + cin when sub=0, and a + ~b + 1 when sub=1, with cin ignored.
REQ-017 The block SHALL be fully pipelined with throughput one operation per cycle and no backpressure; in_valid SHALL be accepted every cycle.
REQ-018 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] using the registered carry of stage k-1 (stage 0 uses the effective carry-in).
REQ-019 Operand chunks for stage k SHALL be delayed by k registers so each chunk meets its carry in the same cycle.
REQ-020 Result chunks produced early SHALL be delayed so that all chunks of one operation emerge together.
REQ-021 An operation sampled with in_valid=1 at rising edge n SHALL produce out_valid=1 with its sum/cout/ovf in the cycle after edge n+STAGES-1 (latency STAGES; STAGES=1 gives a registered adder).
REQ-022 A valid token SHALL travel with each operation; bubbles (in_valid=0) SHALL propagate as out_valid=0 in order.
REQ-023 sum, cout and ovf SHALL update only when a valid operation reaches the output and SHALL hold their last values while out_valid=0.
REQ-024 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1 of the effective addition.
REQ-025 In subtract mode, cout=1 SHALL mean no borrow (a >= b, unsigned).
REQ-026 Wrap-around SHALL be modulo 2^WIDTH; carries across every chunk boundary SHALL be exact, including a carry that ripples through all stages.
REQ-027 sub SHALL be sampled with its operands, so back-to-back operations with mixed modes are independent.

Reset
REQ-028 When rst_n=0 at a rising edge, all valid tokens SHALL clear, and out_valid, sum, cout and ovf SHALL be 0 in the following cycle.
REQ-029 Operations in flight at reset SHALL be discarded and never produce out_valid.
REQ-030 An operation presented in the first cycle with rst_n=1 SHALL complete normally after STAGES cycles.
REQ-031 Pipeline data registers other than the outputs need not be reset.

Verification
REQ-032 (WIDTH=32, CHUNK=8) A bench SHALL check: a=0xFFFFFFFF, b=0, cin=1, sub=0 -> 4 cycles later out_valid=1, sum=0, cout=1, ovf=0 (full carry ripple).
REQ-033 A bench SHALL check: a=0x7FFFFFFF, b=1, sub=0, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-034 A bench SHALL check: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; then a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-035 A bench SHALL check: 100 random operations back-to-back with random bubbles -> outputs match the model in order at latency 4, and held values persist during bubbles.
REQ-036 A bench SHALL check: issue 3 operations, then rst_n=0 for 1 cycle -> none of the 3 produce out_valid, outputs read 0, and a new operation issued immediately after reset completes correctly.
REQ-037 A bench SHALL check: rerunning the checks with CHUNK=32 gives latency 1 and CHUNK=1 gives latency 32, with identical results.
